// File: rtl/btn_debounce_nexys.sv
// Nexys A7 push-button conditioner: 2-flop sync, counter debounce, press/release pulses,
// W1C pending flags and a masked IRQ. Long-press detection is built when BTN_LONGPRESS_EN is defined.
module btn_debounce_nexys #(
  parameter int unsigned NUM_BTN          = 5,
  parameter int unsigned DEBOUNCE_CYCLES  = 500000,
  parameter int unsigned LONGPRESS_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_long,
  output logic [NUM_BTN-1:0] o_pending,
  input  logic [NUM_BTN-1:0] i_pend_clr,
  input  logic [NUM_BTN-1:0] i_irq_en,
  input  logic               i_rel_irq,
  output logic               o_irq
);

  if (NUM_BTN < 1 || NUM_BTN > 16) begin : g_bad_num_btn
    $error("btn_debounce_nexys: NUM_BTN must be in 1..16");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce_nexys: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONGPRESS_CYCLES < 1) begin : g_bad_longpress
    $error("btn_debounce_nexys: LONGPRESS_CYCLES must be >= 1");
  end

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE,
    ST_CHANGING
  } db_state_e;

  db_state_e          state_q [NUM_BTN];
  logic [CW-1:0]      cnt_q   [NUM_BTN];
  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, press_q, release_q, long_q;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic               irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        case (state_q[i])
          ST_STABLE: begin
            // First differing sample already counts as sample #1 of the window.
            if (sync2_q[i] != level_q[i]) begin
              if (DB_LAST == '0) begin
                level_q[i]   <= sync2_q[i];
                press_q[i]   <= sync2_q[i];
                release_q[i] <= ~sync2_q[i];
              end else begin
                cnt_q[i]   <= CW'(1);
                state_q[i] <= ST_CHANGING;
              end
            end
          end
          ST_CHANGING: begin
            if (sync2_q[i] == level_q[i]) begin
              cnt_q[i]   <= '0;
              state_q[i] <= ST_STABLE;
            end else if (cnt_q[i] == DB_LAST) begin
              level_q[i]   <= sync2_q[i];
              press_q[i]   <= sync2_q[i];
              release_q[i] <= ~sync2_q[i];
              cnt_q[i]     <= '0;
              state_q[i]   <= ST_STABLE;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          default: begin
            cnt_q[i]   <= '0;
            state_q[i] <= ST_STABLE;
          end
        endcase
      end
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int unsigned HW = $clog2(LONGPRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONGPRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONGPRESS_CYCLES - 1);

  logic [HW-1:0] hold_q [NUM_BTN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
      long_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        long_q[i] <= level_q[i] && (hold_q[i] == HOLD_LAST);
        if (!level_q[i]) begin
          hold_q[i] <= '0;
        end else if (hold_q[i] != HOLD_MAX) begin
          hold_q[i] <= hold_q[i] + 1'b1;
        end
      end
    end
  end
`else
  assign long_q = '0;
`endif

  assign pending_d = (pending_q & ~i_pend_clr) | press_q
                   | (release_q & {NUM_BTN{i_rel_irq}}) | long_q;

  // IRQ follows the registered pending flags, so it trails a pending update by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |(pending_q & i_irq_en);
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_pending = pending_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_btn_debounce_nexys.sv
// Randomized bench for btn_debounce_nexys with a sliding-window reference model.
// Honors BTN_LONGPRESS_EN the same way as the design.
module tb_btn_debounce_nexys;

  localparam int N = 5;
  localparam int D = 4;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_btn, i_pend_clr, i_irq_en;
  logic         i_rel_irq;
  logic [N-1:0] o_level, o_press, o_release, o_long, o_pending;
  logic         o_irq;

  btn_debounce_nexys #(
    .NUM_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .LONGPRESS_CYCLES(L)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long),
    .o_pending(o_pending), .i_pend_clr(i_pend_clr), .i_irq_en(i_irq_en),
    .i_rel_irq(i_rel_irq), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference: a new level x is accepted when the last D synchronised samples all equal x.
  logic [N-1:0] m_lvl, m_prs, m_rel, m_lng, m_pend, m_s1;
  logic         m_irq;
  logic [31:0]  m_hist [N];
  int           m_rise [N];
  int           edge_n = 0;

  task automatic model_edge();
    logic [N-1:0] nl, np, nr, nlg, npd;
    logic         nirq;
    logic [31:0]  mask, win;
    edge_n++;
    mask = (32'd1 << D) - 32'd1;
    if (rst) begin
      m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_pend = '0; m_irq = 1'b0; m_s1 = '0;
      for (int i = 0; i < N; i++) begin
        m_hist[i] = '0;
        m_rise[i] = 0;
      end
    end else begin
      npd  = (m_pend & ~i_pend_clr) | m_prs | (m_rel & {N{i_rel_irq}}) | m_lng;
      nirq = |(m_pend & i_irq_en);
      nl = m_lvl; np = '0; nr = '0; nlg = '0;
      for (int i = 0; i < N; i++) begin
        win = m_hist[i] & mask;
        if (win == (m_lvl[i] ? 32'd0 : mask)) begin
          nl[i] = ~m_lvl[i];
          np[i] = ~m_lvl[i];
          nr[i] = m_lvl[i];
          if (!m_lvl[i]) m_rise[i] = edge_n;
        end
`ifdef BTN_LONGPRESS_EN
        if (m_lvl[i] && (edge_n - m_rise[i] == L)) nlg[i] = 1'b1;
`endif
        m_hist[i] = {m_hist[i][30:0], m_s1[i]};
      end
      m_s1 = i_btn;
      m_lvl = nl; m_prs = np; m_rel = nr; m_lng = nlg; m_pend = npd; m_irq = nirq;
    end
  endtask

  task automatic check_outputs();
    chk("level",   o_level,   m_lvl);
    chk("press",   o_press,   m_prs);
    chk("release", o_release, m_rel);
    chk("long",    o_long,    m_lng);
    chk("pending", o_pending, m_pend);
    chk("irq",     o_irq,     m_irq);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic clear_all();
    i_pend_clr = '1;
    step(1);
    i_pend_clr = '0;
  endtask

  int n, rel_cnt, long_cnt, rise_t, long_t;
  int unsigned div;

  initial begin
    rst = 1'b1; i_btn = '0; i_pend_clr = '0; i_irq_en = '0; i_rel_irq = 1'b0;
    step(3);
    chk("reset_level", o_level, 0);
    chk("reset_pend", o_pending, 0);
    rst = 1'b0;
    step(3);

    // Clean press on button 0: level/press after 6 edges, pending at 7, irq at 8.
    i_irq_en = 5'h01;
    i_btn[0] = 1'b1;
    n = 0;
    while (n < 20) begin
      step(1); n++;
      if (o_press[0]) break;
    end
    chk("press_lat", n, 6);
    step(1);
    chk("pend_lat", o_pending[0], 1);
    step(1);
    chk("irq_lat", o_irq, 1);
    i_btn[0] = 1'b0;
    step(10);
    clear_all();
    i_irq_en = '0;
    step(2);

    // Short glitches on button 2 must never be accepted.
    for (int g = 0; g < 10; g++) begin
      i_btn[2] = 1'b1;
      step(3);
      i_btn[2] = 1'b0;
      step(2 + int'($urandom % 3));
    end
    step(6);
    chk("glitch_lvl", o_level[2], 0);
    chk("glitch_pend", o_pending, 0);

    // Simultaneous press on buttons 1 and 3; a clear coinciding with the set loses.
    i_btn[1] = 1'b1; i_btn[3] = 1'b1;
    n = 0;
    while (n < 20 && o_press == '0) begin
      step(1); n++;
    end
    chk("dual_press", o_press, 5'h0A);
    i_pend_clr = 5'h02;
    step(1);
    i_pend_clr = '0;
    chk("set_wins", o_pending, 5'h0A);
    step(1);
    i_pend_clr = 5'h02;
    step(1);
    i_pend_clr = '0;
    chk("pend_clr1", o_pending, 5'h08);
    i_btn[1] = 1'b0; i_btn[3] = 1'b0;
    step(12);
    clear_all();

    // Button 4 release, first without then with release-sets-pending.
    for (int r = 0; r < 2; r++) begin
      i_rel_irq = (r == 1);
      i_btn[4] = 1'b1;
      step(10);
      clear_all();
      i_btn[4] = 1'b0;
      rel_cnt = 0;
      for (int k = 0; k < 10; k++) begin
        step(1);
        if (o_release[4]) rel_cnt++;
      end
      chk("rel_pulse", rel_cnt, 1);
      chk("rel_pend", o_pending[4], r);
      clear_all();
    end
    i_rel_irq = 1'b0;

    // Reset during a hold: no release pulse, press re-detected D+2 after reset.
    i_btn[3] = 1'b1;
    step(10);
    rel_cnt = 0;
    rst = 1'b1;
    step(1);
    chk("rst_lvl0", o_level, 0);
    if (o_release[3]) rel_cnt++;
    step(1);
    chk("rst_lvl1", o_level, 0);
    if (o_release[3]) rel_cnt++;
    rst = 1'b0;
    n = 0;
    while (n < 20) begin
      step(1); n++;
      if (o_release[3]) rel_cnt++;
      if (o_press[3]) break;
    end
    chk("rst_relatch", n, D + 2);
    chk("rst_norel", rel_cnt, 0);
    i_btn[3] = 1'b0;
    step(10);
    clear_all();

    // Long hold on button 0.
    i_btn[0] = 1'b1;
    long_cnt = 0; rise_t = -1; long_t = -1;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (o_press[0]) rise_t = k;
      if (o_long[0]) begin
        long_cnt++;
        long_t = k;
      end
    end
`ifdef BTN_LONGPRESS_EN
    chk("long_cnt", long_cnt, 1);
    chk("long_lat", long_t - rise_t, L);
`else
    chk("long_cnt", long_cnt, 0);
`endif
    i_btn[0] = 1'b0;
    step(10);
    clear_all();

    // Randomized segments with varying bounce rates.
    for (int seg = 0; seg < 15; seg++) begin
      div = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 8 : 40);
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < N; b++)
          if ($urandom % div == 0) i_btn[b] = ~i_btn[b];
        i_pend_clr = ($urandom % 4 == 0) ? N'($urandom) : '0;
        if ($urandom % 50 == 0) i_irq_en = N'($urandom);
        if ($urandom % 80 == 0) i_rel_irq = ~i_rel_irq;
        rst = ($urandom % 400 == 0);
        step(1);
      end
    end
    rst = 1'b0;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
